// File: rtl/pacman_pkg.sv
// Shared pac-man definitions: direction codes, screen size and ghost FSM states.
package pacman_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        MOVE,
        FROZEN
    } ghost_state_t;

endpackage

// File: rtl/ghost_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) with seed reload on lock-up.
module ghost_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    logic feedback;

    assign feedback = q[15] ^ q[13] ^ q[12] ^ q[10];

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= SEED;
        end else if (q == '0) begin
            q <= SEED;
        end else begin
            q <= {q[14:0], feedback};
        end
    end

endmodule

// File: rtl/ghost_engine.sv
// Ghost position, mode and pac collision generator for the pac-man processor.
// Build option: define GHOST_CHASE_EN to steer the ghost toward pac on 3 of 4 steps.
module ghost_engine
    import pacman_pkg::*;
#(
    parameter int unsigned GHOST_X0    = 80,
    parameter int unsigned GHOST_Y0    = 60,
    parameter int unsigned STEP        = 4,
    parameter int unsigned SPRITE      = 8,
    parameter int unsigned X_MAX       = SCREEN_W - SPRITE,
    parameter int unsigned Y_MAX       = SCREEN_H - SPRITE,
    parameter int unsigned MODE_PERIOD = 16,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startGame,
    input  logic       en_ghostRand,
    input  logic       s_game_over,
    input  logic [7:0] xPac,
    input  logic [6:0] yPac,
    output logic [7:0] xGhost,
    output logic [6:0] yGhost,
    output logic       badGhostYes,
    output logic       goodGhosthahaJK,
    output logic       touchingGhost
);

    localparam int unsigned      CNT_W    = (MODE_PERIOD > 1) ? $clog2(MODE_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MODE_PERIOD - 1);
    localparam logic [7:0]       X0       = 8'(GHOST_X0);
    localparam logic [6:0]       Y0       = 7'(GHOST_Y0);
    localparam logic [7:0]       XSTEP    = 8'(STEP);
    localparam logic [6:0]       YSTEP    = 7'(STEP);
    localparam logic [7:0]       XMAX     = 8'(X_MAX);
    localparam logic [6:0]       YMAX     = 7'(Y_MAX);
    localparam logic [8:0]       SPR_X    = 9'(SPRITE);
    localparam logic [7:0]       SPR_Y    = 8'(SPRITE);

    ghost_state_t     state, state_next;
    logic [15:0]      lfsr;
    logic             lfsr_unused;
    logic [CNT_W-1:0] mode_cnt, cnt_next;
    logic [7:0]       x_next, x_left, x_right;
    logic [6:0]       y_next, y_up, y_down;
    logic [8:0]       x_sum;
    logic [7:0]       y_sum;
    logic             bad_next, good_next, touch_next;
    logic signed [8:0] dx;
    logic signed [7:0] dy;
    logic [8:0]       adx;
    logic [7:0]       ady;
    logic             overlap;
    dir_t             dir;
    logic             chase_hold;

    ghost_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr)
    );

    assign lfsr_unused = ^lfsr[14:2];

    // Pac minus ghost, widened by one bit so both operands stay non-negative.
    assign dx      = $signed({1'b0, xPac}) - $signed({1'b0, xGhost});
    assign dy      = $signed({1'b0, yPac}) - $signed({1'b0, yGhost});
    assign adx     = dx[8] ? -dx : dx;
    assign ady     = dy[7] ? -dy : dy;
    assign overlap = (adx < SPR_X) && (ady < SPR_Y);

    assign x_sum   = {1'b0, xGhost} + {1'b0, XSTEP};
    assign y_sum   = {1'b0, yGhost} + {1'b0, YSTEP};
    assign x_left  = (xGhost < XSTEP) ? '0 : xGhost - XSTEP;
    assign x_right = (x_sum > {1'b0, XMAX}) ? XMAX : x_sum[7:0];
    assign y_up    = (yGhost < YSTEP) ? '0 : yGhost - YSTEP;
    assign y_down  = (y_sum > {1'b0, YMAX}) ? YMAX : y_sum[6:0];

`ifdef GHOST_CHASE_EN
    // Chase along the axis with the larger gap (ties to x); stand still if already aligned.
    always_comb begin
        dir        = dir_t'(lfsr[1:0]);
        chase_hold = 1'b0;
        if (lfsr[3:2] != 2'b00) begin
            if (adx >= {1'b0, ady}) begin
                if (dx == '0) begin
                    chase_hold = 1'b1;
                end else begin
                    dir = dx[8] ? DIR_LEFT : DIR_RIGHT;
                end
            end else begin
                dir = dy[7] ? DIR_UP : DIR_DOWN;
            end
        end
    end
`else
    assign dir        = dir_t'(lfsr[1:0]);
    assign chase_hold = 1'b0;
`endif

    always_comb begin
        state_next = state;
        x_next     = xGhost;
        y_next     = yGhost;
        bad_next   = badGhostYes;
        good_next  = goodGhosthahaJK;
        cnt_next   = mode_cnt;
        touch_next = overlap;
        unique case (state)
            IDLE: begin
                touch_next = 1'b0;
                if (startGame) state_next = RUN;
            end
            RUN: begin
                if (s_game_over)       state_next = FROZEN;
                else if (en_ghostRand) state_next = MOVE;
            end
            MOVE: begin
                if (!chase_hold) begin
                    unique case (dir)
                        DIR_UP:    y_next = y_up;
                        DIR_DOWN:  y_next = y_down;
                        DIR_LEFT:  x_next = x_left;
                        DIR_RIGHT: x_next = x_right;
                    endcase
                end
                if (mode_cnt == CNT_LAST) begin
                    cnt_next  = '0;
                    bad_next  = !badGhostYes;
                    good_next = badGhostYes ? lfsr[15] : 1'b0;
                end else begin
                    cnt_next = mode_cnt + 1'b1;
                end
                state_next = s_game_over ? FROZEN : RUN;
            end
            FROZEN: begin
                touch_next = touchingGhost;
                if (startGame) begin
                    x_next     = X0;
                    y_next     = Y0;
                    bad_next   = 1'b1;
                    good_next  = 1'b0;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= IDLE;
            xGhost          <= X0;
            yGhost          <= Y0;
            badGhostYes     <= 1'b1;
            goodGhosthahaJK <= 1'b0;
            touchingGhost   <= 1'b0;
            mode_cnt        <= '0;
        end else begin
            state           <= state_next;
            xGhost          <= x_next;
            yGhost          <= y_next;
            badGhostYes     <= bad_next;
            goodGhosthahaJK <= good_next;
            touchingGhost   <= touch_next;
            mode_cnt        <= cnt_next;
        end
    end

endmodule

// File: tb/tb_ghost_engine.sv
// Directed bench for ghost_engine; a reference LFSR supplies the expected step directions.
module tb_ghost_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       startGame = 1'b0;
    logic       en_ghostRand = 1'b0;
    logic       s_game_over = 1'b0;
    logic [7:0] xPac = '0;
    logic [6:0] yPac = '0;
    logic [7:0] xGhost;
    logic [6:0] yGhost;
    logic       badGhostYes, goodGhosthahaJK, touchingGhost;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [15:0] m_lfsr;
    int          exp_x, exp_y, exp_steps;
    logic        exp_bad, exp_good;

    ghost_engine dut (
        .clk             (clk),
        .reset           (reset),
        .startGame       (startGame),
        .en_ghostRand    (en_ghostRand),
        .s_game_over     (s_game_over),
        .xPac            (xPac),
        .yPac            (yPac),
        .xGhost          (xGhost),
        .yGhost          (yGhost),
        .badGhostYes     (badGhostYes),
        .goodGhosthahaJK (goodGhosthahaJK),
        .touchingGhost   (touchingGhost)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        if (v == 16'h0) return 16'hACE1;
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    always @(posedge clk) m_lfsr <= !reset ? 16'hACE1 : lfsr_next(m_lfsr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        startGame    = 1'b0;
        en_ghostRand = 1'b0;
        s_game_over  = 1'b0;
        reset        = 1'b0;
        tick();
        tick();
        reset     = 1'b1;
        exp_x     = 80;
        exp_y     = 60;
        exp_bad   = 1'b1;
        exp_good  = 1'b0;
        exp_steps = 0;
    endtask

    task automatic start_play();
        startGame = 1'b1;
        tick();
        startGame = 1'b0;
    endtask

    // Waits until the LFSR value of the next cycle matches under mask.
    task automatic wait_lfsr(input string tag, input logic [15:0] mask, input logic [15:0] val);
        logic found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            if ((lfsr_next(m_lfsr) & mask) == val) found = 1'b1;
            else tick();
        end
        check({tag, "_wait"}, found, 1);
    endtask

    task automatic predict_move(input logic [15:0] l);
        int  d;
        logic hold;
        d    = int'(l[1:0]);
        hold = 1'b0;
`ifdef GHOST_CHASE_EN
        begin
            int ddx, ddy, ax, ay;
            ddx = int'(xPac) - exp_x;
            ddy = int'(yPac) - exp_y;
            ax  = (ddx < 0) ? -ddx : ddx;
            ay  = (ddy < 0) ? -ddy : ddy;
            if (l[3:2] != 2'b00) begin
                if (ax >= ay) begin
                    if (ddx == 0) hold = 1'b1;
                    else d = (ddx > 0) ? 3 : 2;
                end else begin
                    d = (ddy > 0) ? 1 : 0;
                end
            end
        end
`endif
        if (!hold) begin
            case (d)
                0: exp_y = (exp_y < 4) ? 0 : exp_y - 4;
                1: exp_y = (exp_y + 4 > 112) ? 112 : exp_y + 4;
                2: exp_x = (exp_x < 4) ? 0 : exp_x - 4;
                default: exp_x = (exp_x + 4 > 152) ? 152 : exp_x + 4;
            endcase
        end
        exp_steps++;
        if (exp_steps % 16 == 0) begin
            exp_good = exp_bad ? l[15] : 1'b0;
            exp_bad  = !exp_bad;
        end
    endtask

    task automatic step(input string tag);
        logic [15:0] l;
        int          old_x, old_y;
        old_x        = exp_x;
        old_y        = exp_y;
        en_ghostRand = 1'b1;
        tick();
        en_ghostRand = 1'b0;
        l = m_lfsr;
        check({tag, "_x_lat"}, xGhost, old_x);
        check({tag, "_y_lat"}, yGhost, old_y);
        predict_move(l);
        tick();
        check({tag, "_x"}, xGhost, exp_x);
        check({tag, "_y"}, yGhost, exp_y);
        check({tag, "_bad"}, badGhostYes, exp_bad);
        check({tag, "_good"}, goodGhosthahaJK, exp_good);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and IDLE immunity to step requests
        do_reset();
        check("rst_x", xGhost, 80);
        check("rst_y", yGhost, 60);
        check("rst_bad", badGhostYes, 1);
        check("rst_good", goodGhosthahaJK, 0);
        check("rst_touch", touchingGhost, 0);
        xPac = 8'd80;
        yPac = 7'd60;
        for (int i = 0; i < 20; i++) begin
            en_ghostRand = ~en_ghostRand;
            tick();
        end
        en_ghostRand = 1'b0;
        check("idle_x", xGhost, 80);
        check("idle_y", yGhost, 60);
        check("idle_touch", touchingGhost, 0);

        // Rightward steps up to saturation, mode flip at step 16
        xPac = '0;
        yPac = '0;
        start_play();
        for (int i = 0; i < 20; i++) begin
            wait_lfsr("right", 16'h000F, 16'h0003);
            step("right");
            check("right_le_max", xGhost <= 8'd152, 1);
            if (i == 15) check("flip16_bad", badGhostYes, 0);
        end
        check("sat_x", xGhost, 152);

        // Remaining steps to 32: second flip back to harmful
        while (exp_steps < 32) step("mode");
        check("flip32_bad", badGhostYes, 1);
        check("flip32_good", goodGhosthahaJK, 0);

        // Bounding-box overlap from (80,60)
        do_reset();
        start_play();
        xPac = 8'd87; yPac = 7'd60; tick(); check("touch_87_60", touchingGhost, 1);
        xPac = 8'd88; yPac = 7'd60; tick(); check("touch_88_60", touchingGhost, 0);
        xPac = 8'd73; yPac = 7'd53; tick(); check("touch_73_53", touchingGhost, 1);
        xPac = 8'd72; yPac = 7'd60; tick(); check("touch_72_60", touchingGhost, 0);
        xPac = 8'd80; yPac = 7'd68; tick(); check("touch_80_68", touchingGhost, 0);
        xPac = 8'd80; yPac = 7'd67; tick(); check("touch_80_67", touchingGhost, 1);

        // Game over wins over a same-cycle step; restart reloads
        xPac = '0;
        yPac = '0;
        tick();
        for (int i = 0; i < 3; i++) step("pre_frz");
        s_game_over  = 1'b1;
        en_ghostRand = 1'b1;
        tick();
        en_ghostRand = 1'b0;
        tick();
        tick();
        check("frz_x", xGhost, exp_x);
        check("frz_y", yGhost, exp_y);
        en_ghostRand = 1'b1;
        tick();
        en_ghostRand = 1'b0;
        tick();
        tick();
        check("frz_en_x", xGhost, exp_x);
        check("frz_en_y", yGhost, exp_y);
        s_game_over = 1'b0;
        start_play();
        exp_x     = 80;
        exp_y     = 60;
        exp_bad   = 1'b1;
        exp_good  = 1'b0;
        exp_steps = 0;
        check("restart_x", xGhost, 80);
        check("restart_y", yGhost, 60);
        check("restart_bad", badGhostYes, 1);
        step("post_restart");

        // Reset during MOVE discards the step
        en_ghostRand = 1'b1;
        tick();
        en_ghostRand = 1'b0;
        reset        = 1'b0;
        tick();
        check("rst_move_x", xGhost, 80);
        check("rst_move_y", yGhost, 60);
        reset = 1'b1;

`ifdef GHOST_CHASE_EN
        do_reset();
        start_play();
        xPac = 8'd20;
        yPac = 7'd58;
        wait_lfsr("chase", 16'h000C, 16'h0004);
        step("chase");
        check("chase_x76", xGhost, 76);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
